// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// One requester's view of the shared RAM port arbiter.
//   req_valid/req_ready : request handshake, accepted when both are high
//   req_we              : 1 = write, 0 = read
//   req_addr            : word address
//   req_wdata/req_wbe   : write data and byte enables (writes only)
//   req_lock            : ask for back-to-back grants
//   resp_valid          : one-cycle response pulse for every accepted request
//   resp_rdata          : read data, valid with resp_valid
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [AWIDTH-1:0]     req_addr;
    logic [DWIDTH-1:0]     req_wdata;
    logic [DWIDTH/8-1:0]   req_wbe;
    logic                  req_lock;
    logic                  resp_valid;
    logic [DWIDTH-1:0]     resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wbe, req_lock,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wbe, req_lock,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one port of a byte-enable data RAM between requester A (CPU data
// path) and requester B (DMA/loader). Round-robin arbitration with bounded
// lock bursts; each transaction takes IDLE -> ACCESS -> RESP (3 cycles).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   a_if, b_if   : requester interfaces (slave modport)
//   ram_addr_o   : RAM word address (registered, holds last value)
//   ram_d_o      : RAM write data (registered, holds last value)
//   ram_wen_o    : RAM write enable, high only during ACCESS of a write
//   ram_wbe_o    : RAM byte enables, zero outside ACCESS
//   ram_q_i      : RAM asynchronous read data
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 14,
    parameter int MAX_LOCK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_port_arbiter_if.slave     a_if,
    ram_port_arbiter_if.slave     b_if,
    output logic [AWIDTH-1:0]     ram_addr_o,
    output logic [DWIDTH-1:0]     ram_d_o,
    output logic                  ram_wen_o,
    output logic [DWIDTH/8-1:0]   ram_wbe_o,
    input  logic [DWIDTH-1:0]     ram_q_i
);
    localparam int BE_W   = DWIDTH / 8;
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(MAX_LOCK);
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic                last_win_q, last_win_d;   // also the owner of the transaction in flight
    logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [AWIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DWIDTH-1:0]   ram_d_q, ram_d_d;
    logic                ram_wen_q, ram_wen_d;
    logic [BE_W-1:0]     ram_wbe_q, ram_wbe_d;
    logic                a_resp_valid_q, a_resp_valid_d;
    logic                b_resp_valid_q, b_resp_valid_d;
    logic [DWIDTH-1:0]   a_rdata_q, a_rdata_d;
    logic [DWIDTH-1:0]   b_rdata_q, b_rdata_d;

    logic                last_lock_s;
    logic                keep_s;
    logic                win_s;
    logic                win_lock_s;
    logic                grant_s;

    // Arbitration: pick the winner among valid requesters while idle.
    always_comb begin
        last_lock_s = 1'b0;
        keep_s      = 1'b0;
        win_s       = SEL_A;
        win_lock_s  = 1'b0;
        grant_s     = 1'b0;

        if (last_win_q == SEL_B) begin
            last_lock_s = b_if.req_lock;
        end else begin
            last_lock_s = a_if.req_lock;
        end

        // The last winner keeps the port only while its burst is still short of MAX_LOCK.
        keep_s = (lock_cnt_q != {LOCK_W{1'b0}}) && last_lock_s && (lock_cnt_q < LOCK_MAX);

        if (a_if.req_valid && b_if.req_valid) begin
            if (keep_s) begin
                win_s = last_win_q;
            end else begin
                win_s = rr_ptr_q;
            end
        end else if (b_if.req_valid) begin
            win_s = SEL_B;
        end else begin
            win_s = SEL_A;
        end

        if (win_s == SEL_B) begin
            win_lock_s = b_if.req_lock;
        end else begin
            win_lock_s = a_if.req_lock;
        end

        // Gated by rst_n so ready is guaranteed low while reset is held.
        grant_s = rst_n && (state_q == ST_IDLE) && (a_if.req_valid || b_if.req_valid);
    end

    assign a_if.req_ready  = grant_s && (win_s == SEL_A);
    assign b_if.req_ready  = grant_s && (win_s == SEL_B);
    assign a_if.resp_valid = a_resp_valid_q;
    assign b_if.resp_valid = b_resp_valid_q;
    assign a_if.resp_rdata = a_rdata_q;
    assign b_if.resp_rdata = b_rdata_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_d_o         = ram_d_q;
    assign ram_wen_o       = ram_wen_q;
    assign ram_wbe_o       = ram_wbe_q;

    // Next-state and registered-output logic of the transaction FSM.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        last_win_d     = last_win_q;
        lock_cnt_d     = lock_cnt_q;
        ram_addr_d     = ram_addr_q;
        ram_d_d        = ram_d_q;
        ram_wen_d      = 1'b0;
        ram_wbe_d      = {BE_W{1'b0}};
        a_resp_valid_d = 1'b0;
        b_resp_valid_d = 1'b0;
        a_rdata_d      = a_rdata_q;
        b_rdata_d      = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    state_d    = ST_ACCESS;
                    last_win_d = win_s;
                    rr_ptr_d   = ~win_s;
                    if ((win_s == last_win_q) && win_lock_s) begin
                        if (lock_cnt_q >= LOCK_MAX) begin
                            lock_cnt_d = LOCK_MAX;
                        end else begin
                            lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                        end
                    end else if (win_lock_s) begin
                        lock_cnt_d = LOCK_W'(1);
                    end else begin
                        lock_cnt_d = {LOCK_W{1'b0}};
                    end
                    // The RAM drive registers double as the capture registers.
                    if (win_s == SEL_B) begin
                        ram_wen_d  = b_if.req_we;
                        ram_addr_d = b_if.req_addr;
                        ram_d_d    = b_if.req_wdata;
                        ram_wbe_d  = b_if.req_wbe;
                    end else begin
                        ram_wen_d  = a_if.req_we;
                        ram_addr_d = a_if.req_addr;
                        ram_d_d    = a_if.req_wdata;
                        ram_wbe_d  = a_if.req_wbe;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                // ram_q still shows the pre-write word at this edge.
                if (last_win_q == SEL_B) begin
                    b_rdata_d      = ram_q_i;
                    b_resp_valid_d = 1'b1;
                end else begin
                    a_rdata_d      = ram_q_i;
                    a_resp_valid_d = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= SEL_A;
            last_win_q     <= SEL_A;
            lock_cnt_q     <= {LOCK_W{1'b0}};
            ram_addr_q     <= {AWIDTH{1'b0}};
            ram_d_q        <= {DWIDTH{1'b0}};
            ram_wen_q      <= 1'b0;
            ram_wbe_q      <= {BE_W{1'b0}};
            a_resp_valid_q <= 1'b0;
            b_resp_valid_q <= 1'b0;
            a_rdata_q      <= {DWIDTH{1'b0}};
            b_rdata_q      <= {DWIDTH{1'b0}};
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            last_win_q     <= last_win_d;
            lock_cnt_q     <= lock_cnt_d;
            ram_addr_q     <= ram_addr_d;
            ram_d_q        <= ram_d_d;
            ram_wen_q      <= ram_wen_d;
            ram_wbe_q      <= ram_wbe_d;
            a_resp_valid_q <= a_resp_valid_d;
            b_resp_valid_q <= b_resp_valid_d;
            a_rdata_q      <= a_rdata_d;
            b_rdata_q      <= b_rdata_d;
        end
    end
endmodule
